// File: rtl/data_mem_if.sv
// data_mem_if: valid/ready request and one-cycle response bundle for the data-memory responder
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic [63:0] rdata;
    logic        rsp_err;
    modport slave (
        input  req_valid, mem_read, mem_write, addr, wdata,
        output req_ready, rsp_valid, rdata, rsp_err
    );
    modport master (
        output req_valid, mem_read, mem_write, addr, wdata,
        input  req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder over a DEPTH x 64-bit memory with a fixed response latency
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic       clk,
    input logic       reset,
    data_mem_if.slave bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [3:0]  CNT0  = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic          rd, wr, c_rd, c_wr, err, fin;
    logic [63:0]   a, wd, c_a, c_wd;
    logic [AW-1:0] idx;
    logic [63:0]   mem [DEPTH];
    // With LATENCY=1 the response edge is the accept edge, so the live inputs stand in for the latch
    always_comb begin
        c_rd = state == IDLE ? bus.mem_read : rd;
        c_wr = state == IDLE ? bus.mem_write : wr;
        c_a  = state == IDLE ? bus.addr : a;
        c_wd = state == IDLE ? bus.wdata : wd;
        err  = (c_rd & c_wr) | (c_a[2:0] != 3'd0) | (c_a >= LIMIT);
        idx  = c_a[AW+2:3];
        fin  = state == IDLE ? bus.req_valid && (LATENCY == 1) : state == BUSY && cnt == 4'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rd            <= 1'b0;
            wr            <= 1'b0;
            a             <= '0;
            wd            <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rdata     <= '0;
            bus.rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            bus.rsp_valid <= fin;
            bus.rsp_err   <= fin & err;
            bus.rdata     <= fin && c_rd && !err ? mem[idx] : '0;
            if (fin && c_wr && !err) mem[idx] <= c_wd;
            case (state)
                IDLE: if (bus.req_valid) begin
                    rd            <= bus.mem_read;
                    wr            <= bus.mem_write;
                    a             <= bus.addr;
                    wd            <= bus.wdata;
                    cnt           <= CNT0;
                    bus.req_ready <= 1'b0;
                    state         <= LATENCY == 1 ? RESP : BUSY;
                end
                BUSY: begin
                    cnt   <= cnt - 4'(cnt != 4'd0);
                    state <= cnt == 4'd0 ? RESP : BUSY;
                end
                RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the responder at LATENCY=2 and a LATENCY=1 build
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    data_mem_if b0();
    data_mem_if b1();
    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(b0));
    data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    always #5 clk = ~clk;

    task automatic req(input logic r, input logic w, input logic [63:0] ad, input logic [63:0] wdv,
                       output logic [63:0] rdo, output logic eo, output int lat, output int busy);
        @(negedge clk);
        n_cmp++;
        if (b0.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL req_ready_before_accept: got %b want 1", b0.req_ready);
        end
        b0.req_valid = 1'b1;
        b0.mem_read  = r;
        b0.mem_write = w;
        b0.addr      = ad;
        b0.wdata     = wdv;
        @(negedge clk);
        b0.req_valid = 1'b0;
        b0.mem_read  = ~r;
        b0.mem_write = ~w;
        b0.addr      = ~ad;
        b0.wdata     = ~wdv;
        lat  = 1;
        busy = b0.req_ready ? 0 : 1;
        while (b0.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (b0.req_ready === 1'b0) busy++;
        end
        rdo = b0.rdata;
        eo  = b0.rsp_err;
    endtask

    task automatic expect_rsp(input string nm, input logic [63:0] rdo, input logic eo, input int lat,
                              input logic [63:0] x_rd, input logic x_err);
        n_cmp++;
        if (lat !== 2 || rdo !== x_rd || eo !== x_err) begin
            n_bad++;
            $display("FAIL %s: got lat=%0d rdata=%h err=%b want lat=2 rdata=%h err=%b",
                     nm, lat, rdo, eo, x_rd, x_err);
        end
    endtask

    task automatic test_reset;
        logic [63:0] rdo;
        logic eo;
        int lat, busy;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0 || b0.rdata !== 64'd0 || b0.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got ready=%b vld=%b rdata=%h err=%b want 1 0 0 0",
                     b0.req_ready, b0.rsp_valid, b0.rdata, b0.rsp_err);
        end
        reset = 1'b0;
        req(1, 0, 64'h0, 64'h0, rdo, eo, lat, busy);
        expect_rsp("reset_load0", rdo, eo, lat, 64'd0, 1'b0);
    endtask

    task automatic test_store_load;
        logic [63:0] rdo;
        logic eo;
        int lat, busy;
        req(0, 1, 64'h18, 64'hDEADBEEF_CAFEF00D, rdo, eo, lat, busy);
        expect_rsp("store_18", rdo, eo, lat, 64'd0, 1'b0);
        n_cmp++;
        if (busy !== 2) begin
            n_bad++;
            $display("FAIL store_ready_low: got %0d cycles want 2", busy);
        end
        req(1, 0, 64'h18, 64'h0, rdo, eo, lat, busy);
        expect_rsp("load_18", rdo, eo, lat, 64'hDEADBEEF_CAFEF00D, 1'b0);
        n_cmp++;
        if (busy !== 2) begin
            n_bad++;
            $display("FAIL load_ready_low: got %0d cycles want 2", busy);
        end
        req(0, 0, 64'h18, 64'h1234, rdo, eo, lat, busy);
        expect_rsp("noop_18", rdo, eo, lat, 64'd0, 1'b0);
        req(1, 0, 64'h18, 64'h0, rdo, eo, lat, busy);
        expect_rsp("load_18_after_noop", rdo, eo, lat, 64'hDEADBEEF_CAFEF00D, 1'b0);
    endtask

    task automatic test_errors;
        logic [63:0] rdo;
        logic eo;
        int lat, busy;
        req(1, 0, 64'h1C, 64'h0, rdo, eo, lat, busy);
        expect_rsp("misaligned_load", rdo, eo, lat, 64'd0, 1'b1);
        req(0, 1, 64'h0, 64'h1111, rdo, eo, lat, busy);
        expect_rsp("store_0", rdo, eo, lat, 64'd0, 1'b0);
        req(0, 1, 64'h800, 64'h9999, rdo, eo, lat, busy);
        expect_rsp("store_out_of_range", rdo, eo, lat, 64'd0, 1'b1);
        req(0, 1, 64'h8000_0000_0000_0000, 64'h7777, rdo, eo, lat, busy);
        expect_rsp("store_high_addr", rdo, eo, lat, 64'd0, 1'b1);
        req(1, 0, 64'h0, 64'h0, rdo, eo, lat, busy);
        expect_rsp("mem0_unchanged", rdo, eo, lat, 64'h1111, 1'b0);
        req(0, 1, 64'h7F8, 64'hFEED, rdo, eo, lat, busy);
        expect_rsp("store_last_word", rdo, eo, lat, 64'd0, 1'b0);
        req(1, 0, 64'h7F8, 64'h0, rdo, eo, lat, busy);
        expect_rsp("load_last_word", rdo, eo, lat, 64'hFEED, 1'b0);
        req(1, 1, 64'h20, 64'h5A5A, rdo, eo, lat, busy);
        expect_rsp("read_and_write", rdo, eo, lat, 64'd0, 1'b1);
        req(1, 0, 64'h20, 64'h0, rdo, eo, lat, busy);
        expect_rsp("rw_no_commit", rdo, eo, lat, 64'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [63:0] rdo;
        logic eo;
        int lat, busy;
        logic [63:0] x_rd;
        req(0, 1, 64'h20, 64'hA4, rdo, eo, lat, busy);
        req(0, 1, 64'h38, 64'hA7, rdo, eo, lat, busy);
        req(0, 1, 64'h50, 64'hAA, rdo, eo, lat, busy);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            x_rd = (k == 2) ? 64'hA4 : (k == 5) ? 64'hA7 : (k == 8) ? 64'hAA : 64'h0;
            n_cmp++;
            if (b0.req_ready !== (k % 3 == 0) || b0.rsp_valid !== (k % 3 == 2) || b0.rdata !== x_rd) begin
                n_bad++;
                $display("FAIL backpressure_k%0d: got ready=%b vld=%b rdata=%h want ready=%b vld=%b rdata=%h",
                         k, b0.req_ready, b0.rsp_valid, b0.rdata, k % 3 == 0, k % 3 == 2, x_rd);
            end
            b0.req_valid = 1'b1;
            b0.mem_read  = 1'b1;
            b0.mem_write = 1'b0;
            b0.addr      = 64'(8 * (4 + k));
        end
        @(negedge clk);
        b0.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [63:0] rdo;
        logic eo;
        int lat, busy;
        int seen = 0;
        @(negedge clk);
        b0.req_valid = 1'b1;
        b0.mem_read  = 1'b0;
        b0.mem_write = 1'b1;
        b0.addr      = 64'h8;
        b0.wdata     = 64'h55;
        @(negedge clk);
        b0.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (b0.rsp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_rsp: got %0d pulses want 0", seen);
        end
        req(1, 0, 64'h8, 64'h0, rdo, eo, lat, busy);
        expect_rsp("reset_mid_load8", rdo, eo, lat, 64'd0, 1'b0);
    endtask

    task automatic test_latency1;
        logic [63:0] x_rd;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            x_rd = (k == 3 || k == 5) ? 64'h77 : 64'h0;
            n_cmp++;
            if (b1.req_ready !== (k % 2 == 0) || b1.rsp_valid !== (k % 2 == 1) || b1.rdata !== x_rd || b1.rsp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL lat1_k%0d: got ready=%b vld=%b rdata=%h err=%b want ready=%b vld=%b rdata=%h err=0",
                         k, b1.req_ready, b1.rsp_valid, b1.rdata, b1.rsp_err, k % 2 == 0, k % 2 == 1, x_rd);
            end
            b1.req_valid = 1'b1;
            b1.mem_read  = k != 0;
            b1.mem_write = k == 0;
            b1.addr      = 64'h10;
            b1.wdata     = k == 0 ? 64'h77 : 64'h99;
        end
        @(negedge clk);
        b1.req_valid = 1'b0;
    endtask

    initial begin
        b0.req_valid = 1'b0; b0.mem_read = 1'b0; b0.mem_write = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req_valid = 1'b0; b1.mem_read = 1'b0; b1.mem_write = 1'b0; b1.addr = '0; b1.wdata = '0;
        test_reset;
        test_store_load;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_latency1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
